alu_seq_ctrl: RTL and testbench
===============================

Name: alu_seq_ctrl

Overview:
- Command sequencer for the register-file/ALU datapath. Drives its AD1/AD2/AD3, WE3, ALUsrc, ALUctrl and ImmOp inputs and samples its Zero output.
- Accepts one command at a time over a valid/ready handshake: ADD, ADDI, CMP, or LOOP.
- LOOP repeatedly adds an immediate to a register until it equals a second register, bounded by an iteration cap.
- Sits between the instruction source (testbench or future decoder) and the datapath.

Parameters:
- REG_FILE_ADDR_WIDTH, 5, register address width
- DATA_WIDTH, 32, immediate/data width
- ITER_WIDTH, 16, iteration counter width
- MAX_ITER, 65535, LOOP iteration cap (1..2^ITER_WIDTH-1)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  controller can accept
- cmd_op  in  2  00 ADD, 01 ADDI, 10 CMP, 11 LOOP
- cmd_rd  in  REG_FILE_ADDR_WIDTH  destination register
- cmd_rs1  in  REG_FILE_ADDR_WIDTH  source 1
- cmd_rs2  in  REG_FILE_ADDR_WIDTH  source 2 / LOOP target register
- cmd_imm  in  DATA_WIDTH  signed immediate
- AD1, AD2, AD3  out  REG_FILE_ADDR_WIDTH  register file addresses
- WE3  out  1  register file write enable
- ALUsrc  out  1  0 = RD2, 1 = ImmOp
- ALUctrl  out  1  0 = add, 1 = compare (Zero asserted when operands are equal)
- ImmOp  out  DATA_WIDTH  immediate to the datapath
- Zero  in  1  ALU equality flag, combinational in the same cycle
- busy  out  1  command in progress
- done  out  1  one-cycle completion pulse
- cmp_eq  out  1  result of the last CMP/LOOP compare
- timeout  out  1  LOOP hit MAX_ITER
- iter_count  out  ITER_WIDTH  LOOP add steps executed

Behaviour:
- Reset
  - State is IDLE.
  - cmd_ready=1; busy, done, cmp_eq, timeout, iter_count all 0.
  - Latched command is cleared.
  - Datapath outputs are 0.
  - WE3 is forced 0 combinationally whenever rst=1, including mid-operation.
- States: IDLE, EXEC, L_ADD, L_CMP.
- Datapath outputs are a combinational decode of the state and the latched command. In IDLE all are 0.
- Accept
  - A command is accepted when cmd_valid && cmd_ready at a clk edge.
  - All fields are latched.
  - cmp_eq, timeout and iter_count are cleared.
  - Next state is EXEC for op 00/01/10, L_ADD for op 11.
  - cmd_ready = (state==IDLE).
  - busy = !cmd_ready.
  - cmd_valid while busy is ignored.
- EXEC, one cycle:
  - ADD: AD1=rs1, AD2=rs2, AD3=rd, ALUsrc=0, ALUctrl=0, WE3=1.
  - ADDI: AD1=rs1, AD3=rd, ALUsrc=1, ImmOp=imm, ALUctrl=0, WE3=1.
  - CMP: AD1=rs1, AD2=rs2, ALUsrc=0, ALUctrl=1, WE3=0; cmp_eq<=Zero.
  - At the end of the cycle: go to IDLE and set done<=1.
- L_ADD
  - Outputs: AD1=rd, AD3=rd, ALUsrc=1, ImmOp=imm, ALUctrl=0, WE3=1.
  - iter_count<=iter_count+1; go to L_CMP.
- L_CMP
  - Outputs: AD1=rd, AD2=rs2, ALUsrc=0, ALUctrl=1, WE3=0.
  - Sees the value written in the preceding L_ADD.
  - If Zero: cmp_eq<=1, done<=1, go to IDLE.
  - Else if iter_count==MAX_ITER: timeout<=1, done<=1, go to IDLE.
  - Else go to L_ADD.
  - Zero takes priority over the cap.
- Timing
  - done is high for exactly the one cycle after the final execute cycle.
  - A new command can be accepted in that same cycle, so simple commands run at 2 cycles each.
  - LOOP of N iterations takes 2N execute cycles.
- Status holds: cmp_eq, timeout and iter_count hold until the next accept.
- Address boundaries
  - No special-casing of register 0; the register file owns x0 semantics.
  - LOOP with rd==rs2 terminates after 1 iteration.
  - LOOP with rd=x0 terminates on the first compare if the rs2 register holds 0, otherwise it times out.
- Reset mid-operation
  - Returns to IDLE on the next edge; done is not pulsed.
  - Register writes already committed remain.

Test Plan:
- Reset: rst=1 for 2 cycles, cmd_valid=1 → cmd_ready=1, busy=0, WE3=0, all datapath outputs 0, no accept during reset.
- ADDI x5,x0,7 then ADD x10,x5,x5 back-to-back:
  - First command: EXEC cycle shows AD1=0, AD3=5, ALUsrc=1, ImmOp=7, WE3=1.
  - Second command is accepted in the done cycle.
  - Result: a0=14 and 2 done pulses 2 cycles apart.
- CMP x5,x10 (7 vs 14) → cmp_eq=0, WE3=0 throughout. Then CMP x5,x5 → cmp_eq=1, done one cycle after EXEC.
- ADDI x10,x0,0, then LOOP rd=x10, rs2=x5 (7), imm=1:
  - 14 alternating L_ADD/L_CMP cycles.
  - done, cmp_eq=1, timeout=0, iter_count=7, a0=7.
- MAX_ITER=4, same LOOP from x10=0 → timeout=1, cmp_eq=0, iter_count=4, a0=4.
- Hold cmd_valid=1 during a LOOP; pulse rst in the cycle after the 3rd L_ADD:
  - No accept while busy.
  - WE3=0 in the rst cycle; a0=3 retained.
  - IDLE next cycle, no done pulse, iter_count=0.

Source files
------------

// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: command sequencer for the register-file/ALU datapath.
// Accepts one command at a time (ADD, ADDI, CMP, LOOP) over a valid/ready
// handshake and drives the datapath address/control lines, sampling the
// ALU Zero flag for compares.
//
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   cmd_valid/cmd_ready             command handshake
//   cmd_op/rd/rs1/rs2/imm           command fields (op: 00 ADD, 01 ADDI, 10 CMP, 11 LOOP)
//   AD1, AD2, AD3, WE3              register file addresses / write enable
//   ALUsrc, ALUctrl, ImmOp          ALU operand select, add/compare, immediate
//   Zero                            ALU equality flag (combinational)
//   busy, done                      in-progress flag, one-cycle completion pulse
//   cmp_eq, timeout, iter_count     status of the last command, held until next accept
module alu_seq_ctrl #(
    parameter int REG_FILE_ADDR_WIDTH = 5,
    parameter int DATA_WIDTH          = 32,
    parameter int ITER_WIDTH          = 16,
    parameter int MAX_ITER            = 65535
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           cmd_valid,
    output logic                           cmd_ready,
    input  logic [1:0]                     cmd_op,
    input  logic [REG_FILE_ADDR_WIDTH-1:0] cmd_rd,
    input  logic [REG_FILE_ADDR_WIDTH-1:0] cmd_rs1,
    input  logic [REG_FILE_ADDR_WIDTH-1:0] cmd_rs2,
    input  logic [DATA_WIDTH-1:0]          cmd_imm,
    output logic [REG_FILE_ADDR_WIDTH-1:0] AD1,
    output logic [REG_FILE_ADDR_WIDTH-1:0] AD2,
    output logic [REG_FILE_ADDR_WIDTH-1:0] AD3,
    output logic                           WE3,
    output logic                           ALUsrc,
    output logic                           ALUctrl,
    output logic [DATA_WIDTH-1:0]          ImmOp,
    input  logic                           Zero,
    output logic                           busy,
    output logic                           done,
    output logic                           cmp_eq,
    output logic                           timeout,
    output logic [ITER_WIDTH-1:0]          iter_count
);

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_ADDI = 2'b01;
    localparam logic [1:0] OP_CMP  = 2'b10;
    localparam logic [1:0] OP_LOOP = 2'b11;

    localparam logic [ITER_WIDTH-1:0] ITER_CAP = ITER_WIDTH'(MAX_ITER);

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_L_ADD, S_L_CMP} state_t;

    typedef struct packed {
        logic [1:0]                     op;
        logic [REG_FILE_ADDR_WIDTH-1:0] rd;
        logic [REG_FILE_ADDR_WIDTH-1:0] rs1;
        logic [REG_FILE_ADDR_WIDTH-1:0] rs2;
        logic [DATA_WIDTH-1:0]          imm;
    } cmd_t;

    state_t                state_q, state_d;
    cmd_t                  cmd_q, cmd_d;
    logic                  done_q, done_d;
    logic                  cmp_eq_q, cmp_eq_d;
    logic                  timeout_q, timeout_d;
    logic [ITER_WIDTH-1:0] iter_q, iter_d;
    logic                  we3_raw;

    assign cmd_ready  = (state_q == S_IDLE);
    assign busy       = !cmd_ready;
    assign done       = done_q;
    assign cmp_eq     = cmp_eq_q;
    assign timeout    = timeout_q;
    assign iter_count = iter_q;

    // Reset overrides the decoded write enable so no write can land while
    // the sequencer is being pulled back mid-operation.
    assign WE3 = we3_raw && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cmd_q     <= '0;
            done_q    <= 1'b0;
            cmp_eq_q  <= 1'b0;
            timeout_q <= 1'b0;
            iter_q    <= '0;
        end else begin
            state_q   <= state_d;
            cmd_q     <= cmd_d;
            done_q    <= done_d;
            cmp_eq_q  <= cmp_eq_d;
            timeout_q <= timeout_d;
            iter_q    <= iter_d;
        end
    end

    // Next-state and status update.
    always_comb begin
        state_d   = state_q;
        cmd_d     = cmd_q;
        done_d    = 1'b0;
        cmp_eq_d  = cmp_eq_q;
        timeout_d = timeout_q;
        iter_d    = iter_q;
        unique case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    cmd_d     = '{op: cmd_op, rd: cmd_rd, rs1: cmd_rs1,
                                  rs2: cmd_rs2, imm: cmd_imm};
                    cmp_eq_d  = 1'b0;
                    timeout_d = 1'b0;
                    iter_d    = '0;
                    state_d   = (cmd_op == OP_LOOP) ? S_L_ADD : S_EXEC;
                end
            end
            S_EXEC: begin
                if (cmd_q.op == OP_CMP) cmp_eq_d = Zero;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            S_L_ADD: begin
                iter_d  = iter_q + 1'b1;
                state_d = S_L_CMP;
            end
            S_L_CMP: begin
                // A match on the final permitted iteration counts as a match.
                if (Zero) begin
                    cmp_eq_d = 1'b1;
                    done_d   = 1'b1;
                    state_d  = S_IDLE;
                end else if (iter_q == ITER_CAP) begin
                    timeout_d = 1'b1;
                    done_d    = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    state_d = S_L_ADD;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath decode from state and latched command; everything idles at 0.
    always_comb begin
        AD1     = '0;
        AD2     = '0;
        AD3     = '0;
        we3_raw = 1'b0;
        ALUsrc  = 1'b0;
        ALUctrl = 1'b0;
        ImmOp   = '0;
        unique case (state_q)
            S_EXEC: begin
                AD1 = cmd_q.rs1;
                unique case (cmd_q.op)
                    OP_ADD: begin
                        AD2     = cmd_q.rs2;
                        AD3     = cmd_q.rd;
                        we3_raw = 1'b1;
                    end
                    OP_ADDI: begin
                        AD3     = cmd_q.rd;
                        ALUsrc  = 1'b1;
                        ImmOp   = cmd_q.imm;
                        we3_raw = 1'b1;
                    end
                    OP_CMP: begin
                        AD2     = cmd_q.rs2;
                        ALUctrl = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_L_ADD: begin
                AD1     = cmd_q.rd;
                AD3     = cmd_q.rd;
                ALUsrc  = 1'b1;
                ImmOp   = cmd_q.imm;
                we3_raw = 1'b1;
            end
            S_L_CMP: begin
                AD1     = cmd_q.rd;
                AD2     = cmd_q.rs2;
                ALUctrl = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Bench for alu_seq_ctrl: a behavioural register file/ALU closes the loop
// around the sequencer; a command-level reference model predicts register
// contents, status flags and execute-cycle counts.
module tb_alu_seq_ctrl;

    localparam int AW  = 5;
    localparam int DW  = 32;
    localparam int IW  = 16;
    localparam int MAX = 10;

    localparam logic [1:0] ADD = 2'b00, ADDI = 2'b01, CMP = 2'b10, LOOP = 2'b11;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid, cmd_ready;
    logic [1:0]    cmd_op;
    logic [AW-1:0] cmd_rd, cmd_rs1, cmd_rs2;
    logic [DW-1:0] cmd_imm;
    logic [AW-1:0] AD1, AD2, AD3;
    logic          WE3, ALUsrc, ALUctrl, Zero;
    logic [DW-1:0] ImmOp;
    logic          busy, done, cmp_eq, timeout;
    logic [IW-1:0] iter_count;

    always #5 clk = ~clk;

    alu_seq_ctrl #(.REG_FILE_ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ITER_WIDTH(IW),
                   .MAX_ITER(MAX)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_rd(cmd_rd), .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2),
        .cmd_imm(cmd_imm), .AD1(AD1), .AD2(AD2), .AD3(AD3), .WE3(WE3),
        .ALUsrc(ALUsrc), .ALUctrl(ALUctrl), .ImmOp(ImmOp), .Zero(Zero),
        .busy(busy), .done(done), .cmp_eq(cmp_eq), .timeout(timeout),
        .iter_count(iter_count)
    );

    // Datapath stand-in: x0 reads as zero and ignores writes.
    logic [DW-1:0] regs [32] = '{default: '0};
    logic [DW-1:0] rd1, rd2, srcb;
    assign rd1  = (AD1 == 0) ? '0 : regs[AD1];
    assign rd2  = (AD2 == 0) ? '0 : regs[AD2];
    assign srcb = ALUsrc ? ImmOp : rd2;
    assign Zero = ALUctrl && (rd1 == srcb);
    always @(posedge clk) if (WE3 && AD3 != 0) regs[AD3] <= rd1 + srcb;

    // Reference model state.
    logic [DW-1:0] mregs [32] = '{default: '0};
    int n_vec = 0, n_err = 0;

    function automatic logic [DW-1:0] mv(input logic [AW-1:0] a);
        return (a == 0) ? '0 : mregs[a];
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one command (called at a negedge with the DUT idle), follow it to
    // its done pulse, and check outputs, latency, status and the written register.
    task automatic run(input logic [1:0] op, input logic [AW-1:0] rd, input logic [AW-1:0] rs1,
                       input logic [AW-1:0] rs2, input logic [DW-1:0] imm, output time t_done);
        int exp_cyc, cyc, n;
        logic e_eq, e_to;
        logic [DW-1:0] v;
        chk("ready_before", cmd_ready, 1);
        chk("busy_before", busy, 0);
        e_eq = 0; e_to = 0; n = 0;
        case (op)
            ADD:  begin v = mv(rs1) + mv(rs2); if (rd != 0) mregs[rd] = v; exp_cyc = 1; end
            ADDI: begin v = mv(rs1) + imm;     if (rd != 0) mregs[rd] = v; exp_cyc = 1; end
            CMP:  begin e_eq = (mv(rs1) == mv(rs2)); exp_cyc = 1; end
            default: begin
                do begin
                    if (rd != 0) mregs[rd] = mv(rd) + imm;
                    n++;
                    if (mv(rd) == mv(rs2)) e_eq = 1;
                    else if (n == MAX) e_to = 1;
                end while (!e_eq && !e_to);
                exp_cyc = 2 * n;
            end
        endcase
        cmd_valid = 1; cmd_op = op; cmd_rd = rd; cmd_rs1 = rs1; cmd_rs2 = rs2; cmd_imm = imm;
        @(posedge clk); #1;
        cmd_valid = 0;
        cyc = 0;
        while (cyc < 300) begin
            @(negedge clk);
            if (done) break;
            cyc++;
            if (op != LOOP) begin
                if (cyc == 1) begin
                    chk("ex_busy", busy, 1);
                    chk("ex_ad1", AD1, rs1);
                    chk("ex_we3", WE3, op != CMP);
                    chk("ex_alusrc", ALUsrc, op == ADDI);
                    chk("ex_aluctrl", ALUctrl, op == CMP);
                    if (op != ADDI) chk("ex_ad2", AD2, rs2);
                    if (op != CMP)  chk("ex_ad3", AD3, rd);
                    if (op == ADDI) chk("ex_imm", ImmOp, imm);
                end
            end else if (cyc % 2 == 1) begin
                chk("ladd_ad1", AD1, rd);  chk("ladd_ad3", AD3, rd);
                chk("ladd_src", ALUsrc, 1); chk("ladd_imm", ImmOp, imm);
                chk("ladd_we3", WE3, 1);   chk("ladd_ctl", ALUctrl, 0);
            end else begin
                chk("lcmp_ad1", AD1, rd);  chk("lcmp_ad2", AD2, rs2);
                chk("lcmp_src", ALUsrc, 0); chk("lcmp_we3", WE3, 0);
                chk("lcmp_ctl", ALUctrl, 1);
            end
        end
        chk("done_seen", done, 1);
        chk("exec_cycles", cyc, exp_cyc);
        chk("cmp_eq", cmp_eq, e_eq);
        chk("timeout", timeout, e_to);
        chk("iter_count", iter_count, n);
        if (op != CMP) chk("rd_value", (rd == 0) ? '0 : regs[rd], mv(rd));
        t_done = $time;
    endtask

    // LOOP x10 += 1 until x10 == x5 with cmd_valid held; reset asserted
    // during execute cycle rc (1-based, odd = L_ADD, even = L_CMP).
    task automatic mid_reset(input int rc);
        cmd_valid = 1; cmd_op = LOOP; cmd_rd = 10; cmd_rs1 = 0; cmd_rs2 = 5; cmd_imm = 1;
        @(posedge clk);
        for (int c = 1; c <= rc; c++) begin
            @(negedge clk);
            chk("mr_busy", busy, 1);
            chk("mr_no_done", done, 0);
            chk("mr_iter", iter_count, c / 2);
        end
        rst = 1; #1;
        chk("mr_we3_forced", WE3, 0);
        @(posedge clk); #1;
        rst = 0; cmd_valid = 0;
        @(negedge clk);
        chk("mr_idle", busy, 0);
        chk("mr_no_done_after", done, 0);
        chk("mr_iter_clr", iter_count, 0);
        chk("mr_a0_kept", regs[10], 3);
        mregs[10] = 3;
    endtask

    initial begin
        time t1, t2;
        logic [1:0] op;
        logic [AW-1:0] rd, rs1, rs2;
        logic [DW-1:0] imm, base, step;
        int kk;

        // Reset with a command offered: nothing may be accepted.
        rst = 1; cmd_valid = 1; cmd_op = ADDI; cmd_rd = 3; cmd_rs1 = 0; cmd_rs2 = 0; cmd_imm = 9;
        repeat (2) @(negedge clk);
        chk("rst_ready", cmd_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_we3", WE3, 0);
        chk("rst_dp", {AD1, AD2, AD3, ALUsrc, ALUctrl}, 0);
        chk("rst_imm", ImmOp, 0);
        chk("rst_status", {done, cmp_eq, timeout, iter_count}, 0);
        rst = 0; cmd_valid = 0;
        @(negedge clk);
        chk("post_rst_idle", busy, 0);
        chk("post_rst_x3", regs[3], 0);

        // Back-to-back ADDI/ADD.
        run(ADDI, 5, 0, 0, 7, t1);
        run(ADD, 10, 5, 5, 0, t2);
        chk("b2b_gap", t2 - t1, 20);
        chk("a0_14", regs[10], 14);

        // Compares.
        run(CMP, 0, 5, 10, 0, t1);
        run(CMP, 0, 5, 5, 0, t1);

        // LOOP to 7.
        run(ADDI, 10, 0, 0, 0, t1);
        run(LOOP, 10, 0, 5, 1, t1);
        chk("loop_a0", regs[10], 7);

        // Cap boundaries: match exactly on iteration MAX, then one beyond.
        run(ADDI, 10, 0, 0, 0, t1);
        run(ADDI, 6, 0, 0, MAX, t1);
        run(LOOP, 10, 0, 6, 1, t1);
        run(ADDI, 10, 0, 0, 0, t1);
        run(ADDI, 6, 0, 0, MAX + 1, t1);
        run(LOOP, 10, 0, 6, 1, t1);
        chk("cap_a0", regs[10], MAX);

        // Address corner cases.
        run(LOOP, 7, 0, 7, 3, t1);   // rd == rs2: one iteration
        run(LOOP, 0, 0, 0, 5, t1);   // x0 vs x0: immediate match
        run(LOOP, 0, 0, 5, 5, t1);   // x0 vs 7: times out

        // Reset mid-LOOP, in an L_CMP cycle and in an L_ADD cycle.
        run(ADDI, 10, 0, 0, 0, t1);
        mid_reset(6);
        run(ADDI, 10, 0, 0, 0, t1);
        mid_reset(7);

        // Randomized commands.
        for (int k = 0; k < 30; k++) begin
            op  = 2'($urandom_range(0, 3));
            rd  = AW'($urandom_range(1, 7));
            rs1 = AW'($urandom_range(0, 7));
            rs2 = ($urandom_range(0, 3) == 0) ? rs1 : AW'($urandom_range(0, 7));
            imm = DW'($urandom_range(0, 40)) - 32'd20;
            if (op == LOOP) begin
                rs2  = (rd == 7) ? 5'd1 : rd + 5'd1;
                step = $urandom_range(0, 1) ? 32'd1 : -32'd2;
                kk   = $urandom_range(1, MAX + 2);
                base = $urandom;
                run(ADDI, rd, 0, 0, base, t1);
                run(ADDI, rs2, 0, 0, base + step * DW'(kk), t1);
                imm = step;
            end
            run(op, rd, rs1, rs2, imm, t1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
